bidir_bus_ctrl: RTL and testbench

Half-duplex controller for the team's bidirectional bus buffer. It shares one buffered bidirectional line pair between two requesters: side A drives toward B, or side B drives toward A. It drives the buffer's direction select and a global output enable, and arbitrates round-robin with a bounded burst length. A bus-quiet turnaround is inserted on every direction change, so the two sides never drive the line at the same time.

---
 rtl/bidir_bus_ctrl.sv | 116 +++++++++++
 tb/tb_bidir_bus_ctrl.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/bidir_bus_ctrl.sv
// Half-duplex arbiter for a shared bidirectional bus buffer. It alternates ownership
// round-robin, caps each tenure's length, and inserts bus-quiet cycles before any direction flip.
module bidir_bus_ctrl #(
  parameter int TURN_CYC  = 2,
  parameter int MAX_BURST = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  output logic gnt_a,
  output logic gnt_b,
  output logic dir,
  output logic oe,
  output logic busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TURN  = 2'd1,
    OWN_A = 2'd2,
    OWN_B = 2'd3
  } state_t;

  localparam logic [3:0] TURN_INIT  = 4'(TURN_CYC - 1);
  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);
  localparam logic       SIDE_A     = 1'b0;
  localparam logic       SIDE_B     = 1'b1;

  state_t     state_reg;
  logic [3:0] turn_cnt_reg;
  logic [7:0] burst_cnt_reg;
  logic       last_owner_reg;

  // A tie goes to whichever side did not own the bus last.
  logic win_b;
  logic any_req;
  logic turn_req;

  assign any_req  = req_a | req_b;
  assign win_b    = req_b & (~req_a | (last_owner_reg == SIDE_A));
  assign turn_req = dir ? req_b : req_a;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= IDLE;
      turn_cnt_reg   <= '0;
      burst_cnt_reg  <= '0;
      last_owner_reg <= SIDE_B;
      gnt_a          <= 1'b0;
      gnt_b          <= 1'b0;
      dir            <= 1'b0;
      oe             <= 1'b0;
      busy           <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (any_req) begin
            busy <= 1'b1;
            if (win_b == dir) begin
              state_reg     <= win_b ? OWN_B : OWN_A;
              burst_cnt_reg <= '0;
              gnt_a         <= ~win_b;
              gnt_b         <= win_b;
              oe            <= 1'b1;
            end else begin
              // Direction flips only here, while oe is already low.
              state_reg    <= TURN;
              dir          <= win_b;
              turn_cnt_reg <= TURN_INIT;
            end
          end
        end

        TURN: begin
          if (turn_cnt_reg == 4'd0) begin
            if (turn_req) begin
              state_reg     <= dir ? OWN_B : OWN_A;
              burst_cnt_reg <= '0;
              gnt_a         <= ~dir;
              gnt_b         <= dir;
              oe            <= 1'b1;
            end else begin
              state_reg <= IDLE;
              busy      <= 1'b0;
            end
          end else begin
            turn_cnt_reg <= turn_cnt_reg - 4'd1;
          end
        end

        OWN_A, OWN_B: begin
          if (!(state_reg == OWN_A ? req_a : req_b) || burst_cnt_reg == BURST_LAST) begin
            state_reg      <= IDLE;
            last_owner_reg <= (state_reg == OWN_B) ? SIDE_B : SIDE_A;
            gnt_a          <= 1'b0;
            gnt_b          <= 1'b0;
            oe             <= 1'b0;
            busy           <= 1'b0;
          end else begin
            burst_cnt_reg <= burst_cnt_reg + 8'd1;
          end
        end

        default: begin
          state_reg <= IDLE;
          gnt_a     <= 1'b0;
          gnt_b     <= 1'b0;
          oe        <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bidir_bus_ctrl.sv
// Directed bench for bidir_bus_ctrl: handshake, turnaround, abort, burst limit,
// asynchronous reset and two-sided contention, all with TURN_CYC=2, MAX_BURST=4.
module tb_bidir_bus_ctrl;

  logic clk;
  logic rst;
  logic req_a;
  logic req_b;
  logic gnt_a;
  logic gnt_b;
  logic dir;
  logic oe;
  logic busy;

  int n_cmp;
  int n_bad;

  bidir_bus_ctrl #(.TURN_CYC(2), .MAX_BURST(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .req_a(req_a),
    .req_b(req_b),
    .gnt_a(gnt_a),
    .gnt_b(gnt_b),
    .dir  (dir),
    .oe   (oe),
    .busy (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp = {gnt_a, gnt_b, oe, dir, busy} after the edge that samples ra/rb.
  typedef struct {
    logic       ra;
    logic       rb;
    logic [4:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [4:0] act, input logic [4:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got {ga,gb,oe,dir,busy}=%b expected %b", name, act, exp);
    end else begin
      $display("ok   %s: {ga,gb,oe,dir,busy}=%b", name, act);
    end
  endtask

  initial begin
    logic [1:0] exp_own;
    logic [1:0] act_own;
    int         ph;

    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b0;
    req_a = 1'b0;
    req_b = 1'b0;

    // Handshake on A, dir stays 0
    vecs.push_back('{1'b1, 1'b0, 5'b10101});
    vecs.push_back('{1'b1, 1'b0, 5'b10101});
    vecs.push_back('{1'b1, 1'b0, 5'b10101});
    vecs.push_back('{1'b0, 1'b0, 5'b00000});
    vecs.push_back('{1'b0, 1'b0, 5'b00000});
    // B requests, dir flips, B drops during TURN: abort to IDLE with dir=1
    vecs.push_back('{1'b0, 1'b1, 5'b00011});
    vecs.push_back('{1'b0, 1'b0, 5'b00011});
    vecs.push_back('{1'b0, 1'b0, 5'b00010});
    // B again: no turnaround needed, 1-cycle latency
    vecs.push_back('{1'b0, 1'b1, 5'b01111});
    vecs.push_back('{1'b0, 1'b0, 5'b00010});
    vecs.push_back('{1'b0, 1'b0, 5'b00010});
    // A after B: two quiet TURN cycles
    vecs.push_back('{1'b1, 1'b0, 5'b00001});
    vecs.push_back('{1'b1, 1'b0, 5'b00001});
    vecs.push_back('{1'b1, 1'b0, 5'b10101});
    vecs.push_back('{1'b0, 1'b0, 5'b00000});
    // B after A
    vecs.push_back('{1'b0, 1'b1, 5'b00011});
    vecs.push_back('{1'b0, 1'b1, 5'b00011});
    vecs.push_back('{1'b0, 1'b1, 5'b01111});
    vecs.push_back('{1'b0, 1'b0, 5'b00010});
    // B held over the limit: 4 high, 1 low, re-grant
    vecs.push_back('{1'b0, 1'b1, 5'b01111});
    vecs.push_back('{1'b0, 1'b1, 5'b01111});
    vecs.push_back('{1'b0, 1'b1, 5'b01111});
    vecs.push_back('{1'b0, 1'b1, 5'b01111});
    vecs.push_back('{1'b0, 1'b1, 5'b00010});
    vecs.push_back('{1'b0, 1'b1, 5'b01111});
    vecs.push_back('{1'b0, 1'b0, 5'b00010});

    // Reset asserted between edges
    #2 rst = 1'b1;
    #1 check("reset_initial", {gnt_a, gnt_b, oe, dir, busy}, 5'b00000);
    #5 rst = 1'b0;

    foreach (vecs[i]) begin
      req_a = vecs[i].ra;
      req_b = vecs[i].rb;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d ra=%b rb=%b", i, vecs[i].ra, vecs[i].rb),
            {gnt_a, gnt_b, oe, dir, busy}, vecs[i].exp);
    end

    // Mid-tenure asynchronous reset (B owns, dir=1)
    req_b = 1'b1;
    @(posedge clk);
    #1 check("pre_reset_own_b", {gnt_a, gnt_b, oe, dir, busy}, 5'b01111);
    #3 rst = 1'b1;
    #1 check("reset_mid_tenure", {gnt_a, gnt_b, oe, dir, busy}, 5'b00000);

    // Contention: both held from reset; A 4, quiet 3, B 4, quiet 3, ...
    req_a = 1'b1;
    req_b = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int n = 1; n <= 24; n++) begin
      @(posedge clk);
      #1;
      ph      = (n - 1) % 7;
      exp_own = (ph < 4) ? ((((n - 1) / 7) % 2 == 0) ? 2'b10 : 2'b01) : 2'b00;
      act_own = {gnt_a, gnt_b};
      n_cmp++;
      if (act_own !== exp_own || oe !== (gnt_a | gnt_b)) begin
        n_bad++;
        $display("FAIL contention cycle %0d: got {ga,gb}=%b oe=%b expected {ga,gb}=%b oe=%b",
                 n, act_own, oe, exp_own, |exp_own);
      end else begin
        $display("ok   contention cycle %0d: {ga,gb}=%b oe=%b dir=%b", n, act_own, oe, dir);
      end
    end
    req_a = 1'b0;
    req_b = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
